nios_event_arbiter: RTL and testbench

//  Collects single-cycle event strobes (key/note events) from up to 4 sources into a shared FIFO.

---
 rtl/nios_event_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_nios_event_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_event_arbiter.sv
// ---------------------------------------------------------------------------
// nios_event_arbiter
//   Gathers single-cycle event strobes from up to four sources, queues them
//   round-robin into a shared FIFO and presents the FIFO head as a 32-bit
//   status word for the in_port of a Nios input PIO. Software pops entries by
//   toggling sw_ctrl[0] and clears the sticky overflow flag by holding
//   sw_ctrl[1] high. Single clock domain.
//
//   Ports
//     clk         system clock
//     reset_n     asynchronous active-low reset
//     ev_strobe   [NUM_REQ]     one-cycle event pulse per source
//     ev_data     [NUM_REQ*24]  payload, source i on bits [24*i+23:24*i]
//     sw_ctrl     [2]           [0] pop toggle, [1] overflow clear (level)
//     pio_word    [32]          {valid, overflow, seq[2:0], src[1:0], 0, data[23:0]}
//     fifo_level  [clog2(D)+1]  current FIFO occupancy
//
//   Parameters: NUM_REQ 2..4, FIFO_DEPTH power of two 2..16.
// ---------------------------------------------------------------------------

// Per-source capture register: one pending flag plus the 24-bit payload.
//   strobe_i  event pulse          drain_i  granted by arbiter this cycle
//   pend_o    pending flag         data_o   held payload
//   drop_o    strobe lost because an undrained event is already held
module nios_event_capture (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        strobe_i,
   input  logic [23:0] data_i,
   input  logic        drain_i,
   output logic        pend_o,
   output logic [23:0] data_o,
   output logic        drop_o
);

   logic        pend_q, pend_d;
   logic [23:0] data_q, data_d;

   // A strobe on the drain cycle refills the slot, so it is not a drop.
   assign drop_o = strobe_i & pend_q & ~drain_i;

   always_comb begin
      pend_d = pend_q;
      data_d = data_q;
      if (strobe_i && !drop_o) begin
         pend_d = 1'b1;
         data_d = data_i;
      end else if (drain_i) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= 1'b0;
         data_q <= '0;
      end else begin
         pend_q <= pend_d;
         data_q <= data_d;
      end
   end

   assign pend_o = pend_q;
   assign data_o = data_q;

endmodule

module nios_event_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            ev_strobe,
   input  logic [NUM_REQ*24-1:0]         ev_data,
   input  logic [1:0]                    sw_ctrl,
   output logic [31:0]                   pio_word,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   // Lane signals are padded to four so the 2-bit source id can index them
   // regardless of NUM_REQ; unused lanes tie off to zero.
   logic [3:0]       pend4;
   logic [3:0]       drop4;
   logic [3:0]       drain4;
   logic [3:0][23:0] pdata4;

   for (genvar i = 0; i < 4; i++) begin : g_lane
      if (i < NUM_REQ) begin : g_act
         nios_event_capture u_cap (
            .clk      (clk),
            .reset_n  (reset_n),
            .strobe_i (ev_strobe[i]),
            .data_i   (ev_data[24*i +: 24]),
            .drain_i  (drain4[i]),
            .pend_o   (pend4[i]),
            .data_o   (pdata4[i]),
            .drop_o   (drop4[i])
         );
      end else begin : g_pad
         assign pend4[i]  = 1'b0;
         assign pdata4[i] = '0;
         assign drop4[i]  = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]    rr_ptr_q, rr_ptr_d;
   logic [2:0]    seq_q, seq_d;
   logic          ovf_q, ovf_d;
   logic          hist_q, hist_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   pio_q, pio_d;
   logic [28:0]   mem_q [FIFO_DEPTH];

   // ------------------------------------------------------------------
   // Round-robin arbiter. Space is judged on the registered count only,
   // so a same-cycle pop never makes room for a push.
   // ------------------------------------------------------------------
   logic       space;
   logic       gnt_vld;
   logic [1:0] gnt_idx;
   logic [2:0] cand;

   assign space = (count_q < CW'(FIFO_DEPTH));

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = 2'd0;
      cand    = 3'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = 3'(rr_ptr_q) + 3'(k);
         if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
         if (space && !gnt_vld && pend4[cand[1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[1:0];
         end
      end
   end

   always_comb begin
      drain4 = 4'd0;
      if (gnt_vld) drain4[gnt_idx] = 1'b1;
   end

   // ------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------
   logic        push, pop;
   logic [28:0] push_entry;
   logic [28:0] head;
   logic        valid;

   assign push       = gnt_vld;
   assign push_entry = {seq_q, gnt_idx, pdata4[gnt_idx]};
   // Pop is an edge on the toggle bit; toggles while empty only update history.
   assign pop        = (sw_ctrl[0] ^ hist_q) && (count_q != '0);
   assign head       = mem_q[rd_ptr_q];
   assign valid      = (count_q != '0);

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_vld) rr_ptr_d = (gnt_idx == 2'(NUM_REQ - 1)) ? 2'd0 : gnt_idx + 2'd1;

      seq_d    = push ? seq_q + 3'd1 : seq_q;
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      hist_d   = sw_ctrl[0];

      // A drop on the same cycle as a clear request leaves the flag set.
      ovf_d = ovf_q;
      if (|drop4)          ovf_d = 1'b1;
      else if (sw_ctrl[1]) ovf_d = 1'b0;

      pio_d = {valid, ovf_q, 30'd0};
      if (valid) pio_d[29:0] = {head[28:24], 1'b0, head[23:0]};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q <= 2'd0;
         seq_q    <= 3'd0;
         ovf_q    <= 1'b0;
         hist_q   <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         pio_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         seq_q    <= seq_d;
         ovf_q    <= ovf_d;
         hist_q   <= hist_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pio_q    <= pio_d;
         if (push) mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign pio_word   = pio_q;
   assign fifo_level = count_q;

endmodule

// File: tb/tb_nios_event_arbiter.sv
module tb_nios_event_arbiter;

   localparam int N = 4;
   localparam int D = 8;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [N-1:0]    ev_strobe = '0;
   logic [N*24-1:0] ev_data = '0;
   logic [1:0]      sw_ctrl = '0;
   logic [31:0]     pio_word;
   logic [3:0]      fifo_level;

   int n_tests = 0;
   int n_fail  = 0;

   nios_event_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(D)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ev_strobe  (ev_strobe),
      .ev_data    (ev_data),
      .sw_ctrl    (sw_ctrl),
      .pio_word   (pio_word),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------
   // Behavioural model: FIFO as a queue of formatted words, sources as
   // flag/data arrays, one state update per rising edge.
   // ---------------------------------------------------------------
   logic [29:0] mq[$];
   bit          mpend[N];
   logic [23:0] mpd[N];
   int          mrr = 0, mseq = 0, exp_lvl = 0;
   bit          movf = 0, mhist = 0;
   logic [31:0] exp_pio = '0;

   initial begin : model
      int g;
      bit do_pop, any_drop;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            mq.delete();
            for (int i = 0; i < N; i++) begin mpend[i] = 0; mpd[i] = '0; end
            mrr = 0; mseq = 0; movf = 0; mhist = 0;
            exp_pio = '0; exp_lvl = 0;
         end else begin
            exp_pio = (mq.size() > 0) ? {1'b1, movf, mq[0]} : {1'b0, movf, 30'd0};
            g = -1;
            if (mq.size() < D)
               for (int k = 0; k < N; k++)
                  if (g < 0 && mpend[(mrr + k) % N]) g = (mrr + k) % N;
            do_pop = (sw_ctrl[0] != mhist) && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (g >= 0) begin
               mq.push_back({3'(mseq), 2'(g), 1'b0, mpd[g]});
               mseq = (mseq + 1) % 8;
               mrr  = (g + 1) % N;
            end
            any_drop = 0;
            for (int i = 0; i < N; i++) begin
               if (ev_strobe[i]) begin
                  if (mpend[i] && g != i) any_drop = 1;
                  else begin mpend[i] = 1; mpd[i] = ev_data[24*i +: 24]; end
               end else if (g == i) mpend[i] = 0;
            end
            if (any_drop)        movf = 1;
            else if (sw_ctrl[1]) movf = 0;
            mhist   = sw_ctrl[0];
            exp_lvl = mq.size();
         end
      end
   end

   // Compare every cycle on the falling edge while out of reset.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("model_pio_word", pio_word, exp_pio);
         chk("model_fifo_level", 32'(fifo_level), 32'(exp_lvl));
      end
   end

   // ---------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after the rising edge.
   // ---------------------------------------------------------------
   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic set_ev(input int src, input logic [23:0] d);
      ev_strobe[src]       = 1'b1;
      ev_data[24*src +: 24] = d;
   endtask

   task automatic toggle_pop();
      sw_ctrl[0] = ~sw_ctrl[0];
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      ev_strobe = '0;
      sw_ctrl   = '0;
      tick(2);
      reset_n   = 1'b1;
   endtask

   logic [31:0] t2_exp [4];

   initial begin
      t2_exp = '{32'h8A000022, 32'h94000033, 32'h9E000044, 32'h00000000};

      do_reset();
      chk("reset_pio", pio_word, 32'h0);
      chk("reset_level", 32'(fifo_level), 32'd0);

      // Single uncontended event: latency to the PIO word.
      set_ev(2, 24'h00ABCD); tick(); ev_strobe = '0;
      tick();
      chk("t1_cycle2_not_yet", pio_word, 32'h0);
      tick();
      chk("t1_word", pio_word, 32'h8400ABCD);
      chk("t1_level", 32'(fifo_level), 32'd1);
      toggle_pop(); tick(2);
      chk("t1_after_pop", pio_word, 32'h0);

      // All four sources at once, pushed in round-robin order.
      do_reset();
      for (int i = 0; i < N; i++) set_ev(i, 24'(8'h11 * (i + 1)));
      tick(); ev_strobe = '0;
      tick(4);
      chk("t2_head", pio_word, 32'h80000011);
      chk("t2_level", 32'(fifo_level), 32'd4);
      for (int i = 0; i < 4; i++) begin
         toggle_pop(); tick(2);
         chk("t2_pop_seq", pio_word, t2_exp[i]);
      end

      // Full FIFO with src1 held pending; second src1 strobe is dropped.
      do_reset();
      for (int c = 0; c < 8; c++) begin set_ev(0, 24'h000100 + 24'(c)); tick(); end
      ev_strobe = '0;
      set_ev(1, 24'hBEEF01); tick(); ev_strobe = '0;
      set_ev(1, 24'hDEAD99); tick(); ev_strobe = '0;
      tick();
      chk("t3_ovf_head", pio_word, 32'hC0000100);
      chk("t3_full", 32'(fifo_level), 32'd8);
      toggle_pop(); tick();
      chk("t3_level_after_pop", 32'(fifo_level), 32'd7);
      tick();
      chk("t3_level_refill", 32'(fifo_level), 32'd8);
      chk("t3_next_head", pio_word, 32'hC8000101);
      for (int i = 0; i < 7; i++) begin toggle_pop(); tick(2); end
      chk("t3_src1_kept", pio_word, 32'hC2BEEF01);
      chk("t3_level_one", 32'(fifo_level), 32'd1);

      // Overflow clear racing a drop: set wins, clear on the next cycle.
      sw_ctrl[1] = 1'b1; tick(); sw_ctrl[1] = 1'b0; tick(2);
      chk("t5_cleared_first", 32'(pio_word[30]), 32'd0);
      set_ev(0, 24'hAAAA00); set_ev(1, 24'hBBBB00); tick(); ev_strobe = '0;
      set_ev(1, 24'hCCCC00); sw_ctrl[1] = 1'b1; tick(); ev_strobe = '0;
      tick(); sw_ctrl[1] = 1'b0;
      chk("t5_set_wins", 32'(pio_word[30]), 32'd1);
      tick();
      chk("t5_cleared", 32'(pio_word[30]), 32'd0);

      // Toggle while empty is ignored; pop after a single push.
      do_reset();
      toggle_pop(); tick(2);
      chk("t4_empty_toggle_pio", pio_word, 32'h0);
      chk("t4_empty_toggle_lvl", 32'(fifo_level), 32'd0);
      set_ev(3, 24'h777777); tick(); ev_strobe = '0;
      tick(2);
      chk("t4_word", pio_word, 32'h86777777);
      toggle_pop(); tick();
      chk("t4_k_plus_1", pio_word, 32'h86777777);
      tick();
      chk("t4_k_plus_2", pio_word, 32'h0);
      chk("t4_level", 32'(fifo_level), 32'd0);

      // Reset mid-burst with five entries queued.
      do_reset();
      for (int i = 0; i < N; i++) set_ev(i, 24'(i + 1));
      tick(); ev_strobe = '0;
      set_ev(0, 24'h5); tick(); ev_strobe = '0;
      set_ev(1, 24'h6); tick(); ev_strobe = '0;
      tick(3);
      chk("t6_level_before", 32'(fifo_level), 32'd5);
      #3 reset_n = 1'b0;
      #1;
      chk("t6_async_pio", pio_word, 32'h0);
      chk("t6_async_level", 32'(fifo_level), 32'd0);
      tick(2);
      reset_n = 1'b1;
      set_ev(1, 24'h123456); tick(); ev_strobe = '0;
      tick(2);
      chk("t6_seq_restart", pio_word, 32'h82123456);

      tick(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
